// File: rtl/i2c_slave_regs_if.sv
// Register-port bundle between the I2C target and its register file.
// slave = the I2C target side, master = the register-file/bench side.
interface i2c_slave_regs_if;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic [3:0] state_o;

  modport slave (
    output wr_en, wr_addr, wr_data,
    output rd_addr, busy, state_o,
    input  rd_data
  );

  modport master (
    input  wr_en, wr_addr, wr_data,
    input  rd_addr, busy, state_o,
    output rd_data
  );
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C target with 8-bit register pointer, write/read bursts, auto-increment.
// Optional I2C_SLV_FILTER_EN: 3-sample majority filter on synced scl/sda.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h55,
  parameter logic [7:0] PTR_RST    = 8'h00
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  inout  wire  sda,
  i2c_slave_regs_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    DEV_ADDR = 4'd1,
    DEV_ACK  = 4'd2,
    REG_ADDR = 4'd3,
    REG_ACK  = 4'd4,
    WR_DATA  = 4'd5,
    WR_ACK   = 4'd6,
    RD_DATA  = 4'd7,
    RD_ACK   = 4'd8,
    IGNORE   = 4'd9
  } state_t;

  state_t     state;
  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_in;
  logic       sda_in;
  logic       scl_q;
  logic       sda_q;
  logic [3:0] cnt;
  logic [7:0] shreg;
  logic [7:0] ptr;
  logic       sda_oe;
  logic       ack_on;
  logic       rw;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Two-flop synchronizers; idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
    end
  end

`ifdef I2C_SLV_FILTER_EN
  logic [2:0] scl_h;
  logic [2:0] sda_h;

  // Three-sample history feeding the majority vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_h <= 3'b111;
      sda_h <= 3'b111;
    end else begin
      scl_h <= {scl_h[1:0], scl_sync[1]};
      sda_h <= {sda_h[1:0], sda_sync[1]};
    end
  end

  assign scl_in = (scl_h[0] & scl_h[1]) |
                  (scl_h[1] & scl_h[2]) |
                  (scl_h[0] & scl_h[2]);
  assign sda_in = (sda_h[0] & sda_h[1]) |
                  (sda_h[1] & sda_h[2]) |
                  (sda_h[0] & sda_h[2]);
`else
  assign scl_in = scl_sync[1];
  assign sda_in = sda_sync[1];
`endif

  // Previous line levels for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_in;
      sda_q <= sda_in;
    end
  end

  logic       scl_rise;
  logic       scl_fall;
  logic       start;
  logic       stop;
  logic [7:0] byte_in;

  assign scl_rise = scl_in & ~scl_q;
  assign scl_fall = ~scl_in & scl_q;
  assign start    = scl_in & scl_q & sda_q & ~sda_in;
  assign stop     = scl_in & scl_q & ~sda_q & sda_in;
  assign byte_in  = {shreg[6:0], sda_in};

  // Protocol FSM; START/STOP override every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      ptr     <= PTR_RST;
      sda_oe  <= 1'b0;
      ack_on  <= 1'b0;
      rw      <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (stop) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        ack_on <= 1'b0;
        cnt    <= '0;
      end else if (start) begin
        state  <= DEV_ADDR;
        sda_oe <= 1'b0;
        ack_on <= 1'b0;
        cnt    <= '0;
      end else begin
        unique case (state)
          DEV_ADDR: if (scl_rise) begin
            shreg <= byte_in;
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt   <= '0;
              rw    <= sda_in;
              state <= (shreg[6:0] == SLAVE_ADDR)
                       ? DEV_ACK : IGNORE;
            end
          end
          REG_ADDR: if (scl_rise) begin
            shreg <= byte_in;
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt   <= '0;
              ptr   <= byte_in;
              state <= REG_ACK;
            end
          end
          WR_DATA: if (scl_rise) begin
            shreg <= byte_in;
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt     <= '0;
              wr_en   <= 1'b1;
              wr_addr <= ptr;
              wr_data <= byte_in;
              ptr     <= ptr + 8'd1;
              state   <= WR_ACK;
            end
          end
          DEV_ACK, REG_ACK, WR_ACK: if (scl_fall) begin
            if (!ack_on) begin
              sda_oe <= 1'b1;
              ack_on <= 1'b1;
            end else begin
              ack_on <= 1'b0;
              sda_oe <= 1'b0;
              if (state == DEV_ACK && rw) begin
                shreg  <= bus.rd_data;
                ptr    <= ptr + 8'd1;
                sda_oe <= ~bus.rd_data[7];
                state  <= RD_DATA;
              end else if (state == DEV_ACK) begin
                state <= REG_ADDR;
              end else begin
                state <= WR_DATA;
              end
            end
          end
          RD_DATA: begin
            if (scl_rise) cnt <= cnt + 4'd1;
            if (scl_fall) begin
              if (cnt == 4'd8) begin
                cnt    <= '0;
                sda_oe <= 1'b0;
                state  <= RD_ACK;
              end else begin
                shreg  <= {shreg[6:0], 1'b0};
                sda_oe <= ~shreg[6];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_in) state <= IGNORE;
              else ack_on <= 1'b1;
            end
            if (scl_fall && ack_on) begin
              ack_on <= 1'b0;
              shreg  <= bus.rd_data;
              ptr    <= ptr + 8'd1;
              sda_oe <= ~bus.rd_data[7];
              state  <= RD_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.wr_en   = wr_en;
  assign bus.wr_addr = wr_addr;
  assign bus.wr_data = wr_data;
  assign bus.rd_addr = ptr;
  assign bus.busy    = (state != IDLE);
  assign bus.state_o = state;

endmodule
